// File: rtl/rf_scoreboard.sv
// Register-file hazard scoreboard: one busy bit per register, in-order dual-issue gating, RAW/WAW checks, stall counter.
// Latency: issue1_ok/issue2_ok are combinational; busy_vec and stall_cnt update on the next clk edge.
// Backpressure: a slot is held off by deasserting its issue_ok; slot 2 never issues unless slot 1 does.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   slotN_valid, writeN_*, readNM_* decoder bundle (slot 1 reads 11/12, slot 2 reads 21/22)
//   issue1_ok, issue2_ok          per-slot issue grant
//   wbN_en, wbN_addr              writeback completions clearing busy bits
//   flush                         drop all busy state, block issue this cycle
//   busy_vec, stall_cnt           registered busy bits, saturating stall-cycle count
//
// Build option: define RF_SCB_WB_BYPASS_EN to let a same-cycle writeback release a waiting
// consumer; otherwise the consumer issues the cycle after the writeback.
module rf_scoreboard #(
    parameter int  REGNAME_WIDTH = 5,
    parameter int  CNT_WIDTH     = 16,
    localparam int NUM_REGS      = 2 ** REGNAME_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     slot1_valid,
    input  logic                     slot2_valid,
    input  logic                     write1_en,
    input  logic                     write2_en,
    input  logic [REGNAME_WIDTH-1:0] write1_addr,
    input  logic [REGNAME_WIDTH-1:0] write2_addr,
    input  logic                     read11_en,
    input  logic                     read12_en,
    input  logic                     read21_en,
    input  logic                     read22_en,
    input  logic [REGNAME_WIDTH-1:0] read11_addr,
    input  logic [REGNAME_WIDTH-1:0] read12_addr,
    input  logic [REGNAME_WIDTH-1:0] read21_addr,
    input  logic [REGNAME_WIDTH-1:0] read22_addr,
    output logic                     issue1_ok,
    output logic                     issue2_ok,
    input  logic                     wb1_en,
    input  logic                     wb2_en,
    input  logic [REGNAME_WIDTH-1:0] wb1_addr,
    input  logic [REGNAME_WIDTH-1:0] wb2_addr,
    input  logic                     flush,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic [CNT_WIDTH-1:0]     stall_cnt
);

    logic [NUM_REGS-1:0] wb_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] busy_eff;
    logic                hazard1;
    logic                hazard2;
    logic                intra;
    logic                stall_evt;

    always_comb begin
        wb_mask = '0;
        if (wb1_en) wb_mask[wb1_addr] = 1'b1;
        if (wb2_en) wb_mask[wb2_addr] = 1'b1;
    end

`ifdef RF_SCB_WB_BYPASS_EN
    // Same-cycle writeback hides the busy bit from the hazard checks only.
    assign busy_eff = busy_vec & ~wb_mask;
`else
    assign busy_eff = busy_vec;
`endif

    // busy_vec[0] is never set, so r0 operands can never raise a hazard.
    assign hazard1 = (read11_en & busy_eff[read11_addr])
                   | (read12_en & busy_eff[read12_addr])
                   | (write1_en & busy_eff[write1_addr]);

    assign hazard2 = (read21_en & busy_eff[read21_addr])
                   | (read22_en & busy_eff[read22_addr])
                   | (write2_en & busy_eff[write2_addr]);

    // Slot 2 depending on slot 1's result (RAW or WAW) cannot pair in the same bundle.
    assign intra = write1_en & (write1_addr != '0)
                 & ((read21_en & (read21_addr == write1_addr))
                  | (read22_en & (read22_addr == write1_addr))
                  | (write2_en & (write2_addr == write1_addr)));

    assign issue1_ok = rst_n & ~flush & slot1_valid & ~hazard1;
    assign issue2_ok = rst_n & ~flush & slot2_valid & issue1_ok & ~hazard2 & ~intra;

    always_comb begin
        set_mask = '0;
        if (issue1_ok && write1_en) set_mask[write1_addr] = 1'b1;
        if (issue2_ok && write2_en) set_mask[write2_addr] = 1'b1;
        set_mask[0] = 1'b0;
    end

    assign stall_evt = ~flush & ((slot1_valid & ~issue1_ok) | (slot2_valid & ~issue2_ok));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_vec  <= '0;
            stall_cnt <= '0;
        end else begin
            // Set after clear: a register re-issued in its writeback cycle stays busy.
            if (flush) busy_vec <= '0;
            else       busy_vec <= (busy_vec & ~wb_mask) | set_mask;

            if (stall_evt && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;

`ifdef RF_SCB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic       rst_n, s1v, s2v, w1e, w2e, r11e, r12e, r21e, r22e, wb1e, wb2e, flush;
        logic [4:0] w1a, w2a, r11a, r12a, r21a, r22a, wb1a, wb2a;
    } stim_t;

    typedef struct {
        int          id;
        logic        i1, i2;
        logic        cs;      // compare registered state this cycle
        logic [31:0] busy;
        logic [3:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    stim_t       st;
    logic        issue1_ok, issue2_ok;
    logic [31:0] busy_vec;
    logic [3:0]  stall_cnt;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          step_id = 0;

    always #5 clk = ~clk;

    rf_scoreboard #(.REGNAME_WIDTH(5), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(st.rst_n),
        .slot1_valid(st.s1v), .slot2_valid(st.s2v),
        .write1_en(st.w1e), .write2_en(st.w2e),
        .write1_addr(st.w1a), .write2_addr(st.w2a),
        .read11_en(st.r11e), .read12_en(st.r12e), .read21_en(st.r21e), .read22_en(st.r22e),
        .read11_addr(st.r11a), .read12_addr(st.r12a), .read21_addr(st.r21a), .read22_addr(st.r22a),
        .issue1_ok(issue1_ok), .issue2_ok(issue2_ok),
        .wb1_en(st.wb1e), .wb2_en(st.wb2e), .wb1_addr(st.wb1a), .wb2_addr(st.wb2a),
        .flush(st.flush), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    function automatic void chk(string nm, int id, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
        end
    endfunction

    // Monitor: every cycle the DUT presents a response, compare it with the oldest expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("issue1_ok", e.id, 32'(issue1_ok), 32'(e.i1));
            chk("issue2_ok", e.id, 32'(issue2_ok), 32'(e.i2));
            if (e.cs) begin
                chk("busy_vec", e.id, busy_vec, e.busy);
                chk("stall_cnt", e.id, 32'(stall_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic idle(input logic rst_val = 1'b1);
        st = '{rst_n: rst_val, default: '0};
    endtask

    // Push the expectation for the bundle now on the inputs, then advance one cycle.
    task automatic go(input logic ei1, input logic ei2, input logic cs,
                      input logic [31:0] eb, input int ec);
        exp_t e;
        e.id = step_id; e.i1 = ei1; e.i2 = ei2; e.cs = cs; e.busy = eb; e.cnt = 4'(ec);
        q.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle(1'b0);
        @(posedge clk);
        #1;
        // 0: reset cycle, valid slot must not issue
        idle(1'b0); st.s1v = 1; go(0, 0, 0, 0, 0);
        // 1: slot1 writes r3
        idle(); st.s1v = 1; st.w1e = 1; st.w1a = 3; go(1, 0, 1, 0, 0);
        // 2: slot1 reads busy r3 -> stall
        idle(); st.s1v = 1; st.r11e = 1; st.r11a = 3; go(0, 0, 1, 32'h8, 0);
        // 3: same read with writeback of r3
        idle(); st.s1v = 1; st.r11e = 1; st.r11a = 3; st.wb1e = 1; st.wb1a = 3;
        go(BYP, 0, 1, 32'h8, 1);
        // 4: r3 free now
        idle(); st.s1v = 1; st.r11e = 1; st.r11a = 3; go(1, 0, 1, 0, BYP ? 1 : 2);
        // 5: intra-bundle RAW on r5
        idle(); st.s1v = 1; st.s2v = 1; st.w1e = 1; st.w1a = 5; st.r21e = 1; st.r21a = 5;
        go(1, 0, 1, 0, BYP ? 1 : 2);
        // 6: free r5
        idle(); st.wb1e = 1; st.wb1a = 5; go(0, 0, 1, 32'h20, BYP ? 2 : 3);
        // 7: slot1 writes r0 -> no intra hazard, no busy bit
        idle(); st.s1v = 1; st.s2v = 1; st.w1e = 1; st.w1a = 0; st.r21e = 1; st.r21a = 5;
        go(1, 1, 1, 0, BYP ? 2 : 3);
        // 8: r0 stayed free
        idle(); st.s1v = 1; st.r11e = 1; st.r11a = 0; go(1, 0, 1, 0, BYP ? 2 : 3);
        // 9: slot1 writes r7
        idle(); st.s1v = 1; st.w1e = 1; st.w1a = 7; go(1, 0, 1, 0, BYP ? 2 : 3);
        // 10: slot1 stalled on r7, independent slot2 held in order
        idle(); st.s1v = 1; st.r11e = 1; st.r11a = 7;
        st.s2v = 1; st.w2e = 1; st.w2a = 10; st.r21e = 1; st.r21a = 1;
        go(0, 0, 1, 32'h80, BYP ? 2 : 3);
        // 11: issue writing r9 while wb2 clears r9
        idle(); st.s1v = 1; st.w1e = 1; st.w1a = 9; st.wb2e = 1; st.wb2a = 9;
        go(1, 0, 1, 32'h80, BYP ? 3 : 4);
        // 12: set wins over clear
        idle(); go(0, 0, 1, 32'h280, BYP ? 3 : 4);
        // 13: WAW on busy r9 stalls
        idle(); st.s1v = 1; st.w1e = 1; st.w1a = 9; go(0, 0, 1, 32'h280, BYP ? 3 : 4);
        // 14: flush with valid independent bundle and a writeback
        idle(); st.flush = 1; st.s1v = 1; st.w1e = 1; st.w1a = 2; st.s2v = 1;
        st.wb1e = 1; st.wb1a = 7;
        go(0, 0, 1, 32'h280, BYP ? 4 : 5);
        // 15: busy cleared, counter untouched by flush; dual issue writing r4/r6
        idle(); st.s1v = 1; st.w1e = 1; st.w1a = 4; st.r11e = 1; st.r11a = 0;
        st.s2v = 1; st.w2e = 1; st.w2a = 6; st.r21e = 1; st.r21a = 0;
        go(1, 1, 1, 0, BYP ? 4 : 5);
        // 16: both writeback ports hit r4
        idle(); st.wb1e = 1; st.wb1a = 4; st.wb2e = 1; st.wb2a = 4;
        go(0, 0, 1, 32'h50, BYP ? 4 : 5);
        // 17
        idle(); go(0, 0, 1, 32'h40, BYP ? 4 : 5);
        // 18..31: continuous stall on r6, counter saturates at 15
        for (int k = 0; k < 14; k++) begin
            int ec;
            ec = (BYP ? 4 : 5) + k;
            if (ec > 15) ec = 15;
            idle(); st.s1v = 1; st.r11e = 1; st.r11a = 6;
            go(0, 0, 1, 32'h40, ec);
        end
        // mid-stream reset
        idle(1'b0); st.s1v = 1; st.r11e = 1; st.r11a = 6; go(0, 0, 1, 32'h40, 15);
        // in-flight writeback after reset is ignored
        idle(); st.wb2e = 1; st.wb2a = 6; go(0, 0, 1, 0, 0);
        idle(); st.s1v = 1; st.r11e = 1; st.r11a = 6; go(1, 0, 1, 0, 0);
        idle(); go(0, 0, 1, 0, 0);

        // Bounded drain of the scoreboard queue.
        for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-file hazard scoreboard between the dual-issue instruction decoder and the register file. It tracks one busy bit per architectural register for every issued-but-not-written-back producer. From the decoder's two-slot read/write request bundle it decides each cycle which slots may issue, enforcing in-order issue plus RAW/WAW protection. Busy bits are cleared by two writeback ports, and a saturating counter records stall cycles.

## Interface
Parameters:
- REGNAME_WIDTH, 5, register address width; NUM_REGS = 2**REGNAME_WIDTH (derived, not overridable)
- CNT_WIDTH, 16, stall counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- slot1_valid, slot2_valid  in  1  decoder has an instruction in slot 1 / slot 2
- write1_en, write2_en  in  1  slot writes a target register
- write1_addr, write2_addr  in  REGNAME_WIDTH  target register
- read11_en, read12_en, read21_en, read22_en  in  1  source operand enables (slot 1: 11/12; slot 2: 21/22)
- read11_addr, read12_addr, read21_addr, read22_addr  in  REGNAME_WIDTH  source registers
- issue1_ok, issue2_ok  out  1  slot issues this cycle (combinational)
- wb1_en, wb2_en  in  1  writeback completes
- wb1_addr, wb2_addr  in  REGNAME_WIDTH  writeback register
- flush  in  1  pipeline flush
- busy_vec  out  NUM_REGS  registered busy bits, bit i = register i
- stall_cnt  out  CNT_WIDTH  saturating stall-cycle count

## Operation
- Register 0 is never busy:
  - Reads of r0 never stall.
  - Writes to r0 never set a busy bit.
- A register counts as busy when it is busy(r) = busy_vec[r]. The RF_SCB_WB_BYPASS_EN feature modifies this (see Configuration).
- Slot 1 hazard: any enabled read11/read12 address is busy, or write1_en and write1_addr is busy (WAW).
- issue1_ok = rst_n & !flush & slot1_valid & !hazard1.
- issue2_ok = rst_n & !flush & slot2_valid & issue1_ok & !hazard2 & !intra. Slot 2 never issues ahead of slot 1.
- Slot 2 hazard: same rules as slot 1, applied to read21/read22/write2.
- Intra-bundle hazard (intra): write1_en, write1_addr != 0, and write1_addr equals read21_addr (read21_en), read22_addr (read22_en) or write2_addr (write2_en).
- Set mask: bit write1_addr if issue1_ok & write1_en; bit write2_addr if issue2_ok & write2_en; r0 excluded.
- Clear mask: bit wbN_addr for each asserted wbN_en. Both ports may hit the same register.
- Next state: busy_vec <= (busy_vec & ~clear) | set. Set wins when a register is set and cleared in the same cycle.
- Writeback to a non-busy register: ignored, no error.
- flush: issue1_ok/issue2_ok forced 0 and busy_vec <= 0 at the next edge; writebacks that cycle are discarded.
- stall_cnt increments by 1 when (slot1_valid & !issue1_ok) | (slot2_valid & !issue2_ok), excluding flush cycles.
- stall_cnt saturates at all-ones and is cleared only by reset.

## Timing
- issue_ok has zero latency: combinational from inputs and the current busy_vec.
- A register set by an issue is visible as busy in the following cycle, so a dependent in the next bundle stalls.
- Earliest consumer issue after writeback:
  - Without bypass: the cycle after wbN_en.
  - With bypass: the same cycle as wbN_en.
- Reset (rst_n=0 at edge): busy_vec=0 and stall_cnt=0 after the edge. While rst_n=0, issue1_ok=issue2_ok=0.
- Reset asserted mid-operation drops all outstanding busy state; in-flight writebacks are then ignored.
- The decoder holds a non-issued slot stable until it issues. Slot 2 re-presents as slot 1 by decoder policy; the scoreboard keeps no bundle state.

## Configuration
- RF_SCB_WB_BYPASS_EN defined: busy(r) = busy_vec[r] & !(wb1_en & wb1_addr==r) & !(wb2_en & wb2_addr==r) for hazard checks. A same-cycle writeback releases the dependent instruction immediately.
- RF_SCB_WB_BYPASS_EN undefined: busy(r) = busy_vec[r]. This costs one extra stall cycle per dependency but removes the wb-to-issue combinational path.
- busy_vec next-state logic is identical in both builds.

## Test plan
- Reset, then slot1 writes r3 (issue1_ok=1) -> next cycle busy_vec[3]=1; slot1 reading r3 gives issue1_ok=0 and stall_cnt increments to 1.
- Busy r3, wb1_en with wb1_addr=3 -> with macro, issue1_ok=1 that cycle; without, issue1_ok=0 then 1 next cycle. busy_vec[3]=0 in both builds unless re-set.
- Bundle where slot1 writes r5 and slot2 reads r5, regs free -> issue1_ok=1, issue2_ok=0, busy_vec[5]=1 next cycle. Same bundle with slot1 writing r0 -> both issue, busy_vec stays 0.
- Slot1 stalled on busy r7, slot2 independent -> issue2_ok=0 (in-order). Issue writing r9 while wb2 clears r9 in the same cycle -> busy_vec[9]=1.
- Several busy registers plus flush=1 -> issue_ok=0 that cycle, busy_vec=0 next cycle, stall_cnt unchanged; rst_n=0 mid-stream -> busy_vec=0, stall_cnt=0.
- Preload stall_cnt near all-ones with continuous stalls (CNT_WIDTH=4) -> counter reaches 15 and holds 15.
